// File: rtl/uart_rx_param_if.sv
//==============================================================================
// Module   : uart_rx_param_if
// Purpose  : Receive-word read port (show-ahead valid/ready) of uart_rx_param
// Revision : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;

    modport master (output data_out, output rx_valid, output parity_err, input rx_ready);
    modport slave  (input data_out, input rx_valid, input parity_err, output rx_ready);
endinterface

`default_nettype wire

// File: rtl/uart_rx_param.sv
//==============================================================================
// Module   : uart_rx_param
// Purpose  : Parametrised UART receiver, 3-sample voting, show-ahead RX FIFO
// Revision : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_rx_param #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 2,
    parameter int PARITY      = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       data_in,
    uart_rx_param_if.master rx,
    output logic            frame_err,
    output logic            overrun_err
);

    localparam int c_DIV   = (CLK_FREQ_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
    localparam int c_DIV_W = $clog2(c_DIV + 1);
    localparam int c_S_W   = $clog2(OVERSAMPLE);
    localparam int c_B_W   = $clog2(DATA_BITS + 1);
    localparam int c_P_W   = $clog2(FIFO_DEPTH);
    localparam int c_C_W   = c_P_W + 1;
    localparam int c_W     = DATA_BITS + 1;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_PAR   = 3'd3;
    localparam logic [2:0] c_STOP  = 3'd4;
    localparam logic [2:0] c_BREAK = 3'd5;

    logic [1:0]           r_sync;
    logic                 r_line_d;
    logic [c_DIV_W-1:0]   r_div_cnt;
    logic [c_S_W-1:0]     r_s_cnt;
    logic [1:0]           r_samp;
    logic [c_B_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [c_W-1:0]       r_mem [FIFO_DEPTH];
    logic [c_P_W-1:0]     r_wr_ptr;
    logic [c_P_W-1:0]     r_rd_ptr;
    logic [c_C_W-1:0]     r_count;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic w_line, w_fall, w_tick, w_dec, w_vote, w_par_bad;
    logic w_restart, w_bit_step, w_shift, w_par_cap, w_frame, w_push;
    logic w_full, w_pop, w_wr_en;
    logic [c_W-1:0] w_head;

    // Sampled-line register resets high so a start needs a genuine 1->0 edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync   <= 2'b11;
            r_line_d <= 1'b1;
        end else begin
            r_sync   <= {r_sync[0], data_in};
            r_line_d <= r_sync[1];
        end
    end

    assign w_line = r_sync[1];
    assign w_fall = r_line_d & ~w_line;
    assign w_tick = (r_div_cnt == c_DIV_W'(c_DIV - 1));
    assign w_dec  = w_tick && (r_s_cnt == c_S_W'(OVERSAMPLE / 2 + 1));
    assign w_vote = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_line) | (r_samp[1] & w_line);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_div_cnt <= '0;
        else if (w_restart || w_tick)
            r_div_cnt <= '0;
        else
            r_div_cnt <= r_div_cnt + 1'b1;
    end

    generate
        if (PARITY != 0) begin : g_parity
            // Odd mode wants an odd total of ones over data plus parity bit
            assign w_par_bad = (^r_shift) ^ w_vote ^ (PARITY == 1);
        end else begin : g_no_parity
            assign w_par_bad = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_fall) w_next_state = c_START;
            c_START: if (w_dec) w_next_state = w_vote ? c_IDLE : c_DATA;
            c_DATA:  if (w_dec && (r_bit_cnt == c_B_W'(DATA_BITS - 1)))
                         w_next_state = (PARITY != 0) ? c_PAR : c_STOP;
            c_PAR:   if (w_dec) w_next_state = c_STOP;
            c_STOP:  if (w_dec) begin
                         if (!w_vote)
                             w_next_state = c_BREAK;
                         else if (r_bit_cnt == c_B_W'(STOP_BITS - 1))
                             w_next_state = c_IDLE;
                     end
            c_BREAK: if (w_line) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_restart  = 1'b0;
        w_bit_step = 1'b0;
        w_shift    = 1'b0;
        w_par_cap  = 1'b0;
        w_frame    = 1'b0;
        w_push     = 1'b0;
        case (r_state)
            c_IDLE:  w_restart = w_fall;
            c_START: w_bit_step = w_dec;
            c_DATA: begin
                w_bit_step = w_dec;
                w_shift    = w_dec;
            end
            c_PAR: begin
                w_bit_step = w_dec;
                w_par_cap  = w_dec;
            end
            c_STOP: begin
                w_bit_step = w_dec;
                w_frame    = w_dec & ~w_vote;
                w_push     = w_dec & w_vote & (r_bit_cnt == c_B_W'(STOP_BITS - 1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_cnt   <= '0;
            r_samp    <= 2'b11;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
        end else if (w_restart) begin
            r_s_cnt   <= '0;
            r_bit_cnt <= '0;
            r_par_err <= 1'b0;
        end else begin
            if (w_tick) begin
                r_s_cnt <= (r_s_cnt == c_S_W'(OVERSAMPLE - 1)) ? '0 : r_s_cnt + 1'b1;
                if (r_s_cnt == c_S_W'(OVERSAMPLE / 2 - 1)) r_samp[0] <= w_line;
                if (r_s_cnt == c_S_W'(OVERSAMPLE / 2))     r_samp[1] <= w_line;
            end
            // Bit counter restarts whenever the FSM moves to a new field
            if (w_bit_step)
                r_bit_cnt <= (w_next_state != r_state) ? '0 : r_bit_cnt + 1'b1;
            if (w_shift)
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
            if (w_par_cap)
                r_par_err <= w_par_bad;
        end
    end

    assign w_full  = (r_count == c_C_W'(FIFO_DEPTH));
    assign w_pop   = (r_count != '0) && rx.rx_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= {r_par_err, r_shift};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_frame_err <= w_frame;
            r_overrun   <= w_push && !w_wr_en;
        end
    end

    // Head is masked while empty so the port reads zero out of reset
    assign w_head        = r_mem[r_rd_ptr];
    assign rx.rx_valid   = (r_count != '0);
    assign rx.data_out   = rx.rx_valid ? w_head[DATA_BITS-1:0] : '0;
    assign rx.parity_err = rx.rx_valid & w_head[DATA_BITS];
    assign frame_err     = r_frame_err;
    assign overrun_err   = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_param.sv
//==============================================================================
// Module   : tb_uart_rx_param
// Purpose  : Self-checking bench for uart_rx_param (no-parity 8N2 and even-parity 8E1)
// Revision : 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_param;

    localparam int c_BAUD   = 625_000;
    localparam int c_BIT_NS = 1616;

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } exp_t;

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       pbit;
        logic [7:0] exp_data;
        logic       exp_perr;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic line0 = 1'b1;
    logic line1 = 1'b1;
    logic frame_err0, overrun0, frame_err1, overrun1;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   fe_cnt0 = 0, ov_cnt0 = 0, fe_cnt1 = 0, ov_cnt1 = 0;
    int   pops0 = 0, pops1 = 0;

    always #5 clk = ~clk;

    uart_rx_param_if #(.DATA_BITS(8)) bus0 ();
    uart_rx_param_if #(.DATA_BITS(8)) bus1 ();

    uart_rx_param #(
        .CLK_FREQ_HZ(100_000_000), .BAUD(c_BAUD), .OVERSAMPLE(16),
        .DATA_BITS(8), .STOP_BITS(2), .PARITY(0), .FIFO_DEPTH(4)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(line0), .rx(bus0),
        .frame_err(frame_err0), .overrun_err(overrun0)
    );

    uart_rx_param #(
        .CLK_FREQ_HZ(100_000_000), .BAUD(c_BAUD), .OVERSAMPLE(16),
        .DATA_BITS(8), .STOP_BITS(1), .PARITY(2), .FIFO_DEPTH(4)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(line1), .rx(bus1),
        .frame_err(frame_err1), .overrun_err(overrun1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every pop is compared against the oldest expected word
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err0) fe_cnt0++;
            if (overrun0)   ov_cnt0++;
            if (frame_err1) fe_cnt1++;
            if (overrun1)   ov_cnt1++;
            if (bus0.rx_valid && bus0.rx_ready) begin
                exp_t e;
                pops0++;
                if (q0.size() == 0) begin
                    n_checks++;
                    $display("FAIL dut0 spurious pop: got 0x%0h, expected no word", bus0.data_out);
                end else begin
                    e = q0.pop_front();
                    check("dut0 data", 32'(bus0.data_out), 32'(e.data));
                    check("dut0 perr", 32'(bus0.parity_err), 32'(e.perr));
                end
            end
            if (bus1.rx_valid && bus1.rx_ready) begin
                exp_t e;
                pops1++;
                if (q1.size() == 0) begin
                    n_checks++;
                    $display("FAIL dut1 spurious pop: got 0x%0h, expected no word", bus1.data_out);
                end else begin
                    e = q1.pop_front();
                    check("dut1 data", 32'(bus1.data_out), 32'(e.data));
                    check("dut1 perr", 32'(bus1.parity_err), 32'(e.perr));
                end
            end
        end
    end

    function automatic logic [15:0] frm0(input logic [7:0] d);
        return {5'b0, 2'b11, d, 1'b0};
    endfunction

    function automatic logic [15:0] frm1(input logic [7:0] d, input logic p);
        return {5'b0, 1'b1, p, d, 1'b0};
    endfunction

    task automatic send(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) line0 = bits[i];
            else            line1 = bits[i];
            #(c_BIT_NS);
        end
    endtask

    task automatic set_ready(input int which, input logic v);
        @(posedge clk);
        #1;
        if (which == 0) bus0.rx_ready = v;
        else            bus1.rx_ready = v;
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 20000 && (q0.size() != 0 || q1.size() != 0); c++)
            @(negedge clk);
        check({tag, " dut0 words outstanding"}, 32'(q0.size()), 0);
        check({tag, " dut1 words outstanding"}, 32'(q1.size()), 0);
    endtask

    task automatic push0(input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.perr = 1'b0;
        q0.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected bench completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   base_fe, base_ov, base_pops;

        vecs[0] = '{0, 8'h39, 1'b0, 8'h39, 1'b0};
        vecs[1] = '{0, 8'h8E, 1'b0, 8'h8E, 1'b0};
        vecs[2] = '{0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{0, 8'hFF, 1'b0, 8'hFF, 1'b0};
        vecs[4] = '{1, 8'hA5, 1'b1, 8'hA5, 1'b1};
        vecs[5] = '{1, 8'h3C, 1'b0, 8'h3C, 1'b0};
        vecs[6] = '{1, 8'h01, 1'b1, 8'h01, 1'b0};
        vecs[7] = '{1, 8'h07, 1'b0, 8'h07, 1'b1};

        bus0.rx_ready = 1'b1;
        bus1.rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("reset dut0 rx_valid", 32'(bus0.rx_valid), 0);
        check("reset dut0 data_out", 32'(bus0.data_out), 0);
        check("reset dut0 parity_err", 32'(bus0.parity_err), 0);
        check("reset dut0 frame_err", 32'(frame_err0), 0);
        check("reset dut0 overrun_err", 32'(overrun0), 0);
        check("reset dut1 rx_valid", 32'(bus1.rx_valid), 0);
        check("reset dut1 data_out", 32'(bus1.data_out), 0);
        check("reset dut1 frame_err", 32'(frame_err1), 0);
        rst_n = 1'b1;
        #(c_BIT_NS);

        // Table of frames, sent back to back
        for (int i = 0; i < 8; i++) begin
            exp_t e;
            e.data = vecs[i].exp_data;
            e.perr = vecs[i].exp_perr;
            if (vecs[i].dut == 0) begin
                q0.push_back(e);
                send(0, frm0(vecs[i].data), 11);
            end else begin
                q1.push_back(e);
                send(1, frm1(vecs[i].data, vecs[i].pbit), 11);
            end
        end
        drain("table");
        check("table dut0 frame_err pulses", 32'(fe_cnt0), 0);
        check("table dut0 overrun pulses", 32'(ov_cnt0), 0);
        check("table dut1 frame_err pulses", 32'(fe_cnt1), 0);
        check("table dut1 overrun pulses", 32'(ov_cnt1), 0);

        // Stop bit held low for three bit times
        base_fe   = fe_cnt0;
        base_pops = pops0;
        send(0, {4'b0, 3'b000, 8'h55, 1'b0}, 12);
        line0 = 1'b1;
        #(2 * c_BIT_NS);
        check("break frame_err pulse cycles", 32'(fe_cnt0 - base_fe), 1);
        check("break nothing pushed", 32'(pops0 - base_pops), 0);
        push0(8'h12);
        send(0, frm0(8'h12), 11);
        drain("after break");

        // Five frames into a four-deep FIFO with the consumer stalled
        set_ready(0, 1'b0);
        base_ov   = ov_cnt0;
        base_pops = pops0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) push0(8'(i));
            send(0, frm0(8'(i)), 11);
        end
        #(c_BIT_NS);
        check("overrun pulse cycles", 32'(ov_cnt0 - base_ov), 1);
        check("overrun rx_valid held", 32'(bus0.rx_valid), 1);
        check("overrun no pops while stalled", 32'(pops0 - base_pops), 0);
        set_ready(0, 1'b1);
        drain("overrun");

        // Short low glitch on an idle line
        base_fe   = fe_cnt0;
        base_pops = pops0;
        line0 = 1'b0;
        #200;
        line0 = 1'b1;
        #(3 * c_BIT_NS);
        check("idle glitch no push", 32'(pops0 - base_pops), 0);
        check("idle glitch no frame_err", 32'(fe_cnt0 - base_fe), 0);
        check("idle glitch rx_valid", 32'(bus0.rx_valid), 0);

        // One-sample glitch centred in data bit 3 of 0xF0
        push0(8'hF0);
        fork
            send(0, frm0(8'hF0), 11);
            begin
                #(4 * c_BIT_NS + 791);
                line0 = ~line0;
                #80;
                line0 = ~line0;
            end
        join
        drain("mid-bit glitch");

        // Reset during data bit 4 with two words queued
        set_ready(0, 1'b0);
        send(0, frm0(8'h11), 11);
        send(0, frm0(8'h22), 11);
        check("pre-reset words queued", 32'(bus0.rx_valid), 1);
        fork
            send(0, frm0(8'hF0), 11);
            begin
                #(5 * c_BIT_NS + 800);
                rst_n = 1'b0;
                @(negedge clk);
                check("mid reset rx_valid", 32'(bus0.rx_valid), 0);
                check("mid reset data_out", 32'(bus0.data_out), 0);
                check("mid reset parity_err", 32'(bus0.parity_err), 0);
                check("mid reset frame_err", 32'(frame_err0), 0);
                check("mid reset overrun_err", 32'(overrun0), 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        join
        #(c_BIT_NS);
        check("post reset FIFO empty", 32'(bus0.rx_valid), 0);
        set_ready(0, 1'b1);
        push0(8'h7E);
        send(0, frm0(8'h7E), 11);
        drain("after reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
